// File: rtl/cse_datapath_seq_if.sv
// Operand/result bus for cse_datapath_seq.
//   a, b, c, d        : operands, taken when in_valid && in_ready
//   in_valid/in_ready : input handshake
//   s1..s6, div_zero  : registered results, valid while out_valid
//   out_valid/out_ready : output handshake
// master = producer/consumer side, slave = the datapath.
interface cse_datapath_seq_if #(
  parameter int BW = 8
);
  logic [BW-1:0] a, b, c, d;
  logic          in_valid, in_ready;
  logic [BW-1:0] s1, s2, s3, s4, s5, s6;
  logic          div_zero, out_valid, out_ready;

  modport master (
    output a, b, c, d, in_valid, out_ready,
    input  in_ready, s1, s2, s3, s4, s5, s6, div_zero, out_valid
  );

  modport slave (
    input  a, b, c, d, in_valid, out_ready,
    output in_ready, s1, s2, s3, s4, s5, s6, div_zero, out_valid
  );
endinterface

// File: rtl/cse_datapath_seq.sv
// Shared-subexpression datapath with a sequential restoring divider.
// Captures a, b, c, d, spends BW cycles producing a mod b one bit per
// cycle, then loads all results at once and holds them until taken.
//   s1 = a+b        s2 = a*b          s3 = (a mod b)+d
//   s4 = c+d+a*b    s5 = a-b          s6 = a*b+a+d+c-b  (== (b+1)*a+d+c-b)
// Ports: clk, rst_n (async, active low), bus (cse_datapath_seq_if.slave).
module cse_datapath_seq #(
  parameter int BW = 8
) (
  input logic               clk,
  input logic               rst_n,
  cse_datapath_seq_if.slave bus
);
  localparam int            CW   = (BW > 2) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [BW-1:0] a, b, c, d;
  } opnd_t;

  typedef struct packed {
    logic [BW-1:0] s1, s2, s3, s4, s5, s6;
    logic          div_zero;
  } res_t;

  logic [1:0]    state;
  opnd_t         op;
  res_t          res;
  logic [CW-1:0] cnt;
  logic [BW-1:0] rem;   // partial remainder
  logic [BW-1:0] dvd;   // dividend shift register, MSB feeds the remainder

  // One restoring step. With b == 0 the compare always succeeds and
  // subtracts nothing, so the remainder simply collects a: a mod 0 = a.
  logic [BW:0]   rem_sh;
  logic [BW-1:0] rem_nxt, dvd_nxt;

  always_comb begin
    rem_sh  = {rem, dvd[BW-1]};
    rem_nxt = rem_sh[BW-1:0];
    dvd_nxt = {dvd[BW-2:0], 1'b0};
    if (rem_sh >= {1'b0, op.b}) begin
      rem_nxt = BW'(rem_sh - {1'b0, op.b});
      dvd_nxt = {dvd[BW-2:0], 1'b1};
    end
  end

  // Single multiplier; s4 and s6 both hang off its product.
  logic [BW-1:0] prod;
  res_t          res_nxt;

  always_comb begin
    prod             = op.a * op.b;
    res_nxt.s1       = op.a + op.b;
    res_nxt.s2       = prod;
    res_nxt.s3       = rem_nxt + op.d;
    res_nxt.s4       = op.c + op.d + prod;
    res_nxt.s5       = op.a - op.b;
    res_nxt.s6       = prod + op.a + op.d + op.c - op.b;
    res_nxt.div_zero = (op.b == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= '0;
      res   <= '0;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op    <= '{a: bus.a, b: bus.b, c: bus.c, d: bus.d};
          dvd   <= bus.a;
          rem   <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            res   <= res_nxt;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // rst_n gates in_ready so it is low for the whole reset, not just
  // after the first edge.
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.s1        = res.s1;
  assign bus.s2        = res.s2;
  assign bus.s3        = res.s3;
  assign bus.s4        = res.s4;
  assign bus.s5        = res.s5;
  assign bus.s6        = res.s6;
  assign bus.div_zero  = res.div_zero;
endmodule

// File: tb/tb_cse_datapath_seq.sv
module tb_cse_datapath_seq;
  localparam int BW = 8;

  typedef struct {
    logic [BW-1:0] s1, s2, s3, s4, s5, s6;
    logic          dz;
  } exp_t;

  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t cur;

  cse_datapath_seq_if #(.BW(BW)) bus ();
  cse_datapath_seq #(.BW(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [BW-1:0] a, b, c, d);
    exp_t e;
    logic [BW-1:0] m;
    m    = (b == 0) ? a : a % b;
    e.s1 = a + b;
    e.s2 = a * b;
    e.s3 = m + d;
    e.s4 = c + d + a * b;
    e.s5 = a - b;
    e.s6 = (b + 1) * a + d + c - b;
    e.dz = (b == 0);
    return e;
  endfunction

  task automatic cmp_res(input string tag);
    chk({tag, "_s1"}, 32'(bus.s1), 32'(cur.s1));
    chk({tag, "_s2"}, 32'(bus.s2), 32'(cur.s2));
    chk({tag, "_s3"}, 32'(bus.s3), 32'(cur.s3));
    chk({tag, "_s4"}, 32'(bus.s4), 32'(cur.s4));
    chk({tag, "_s5"}, 32'(bus.s5), 32'(cur.s5));
    chk({tag, "_s6"}, 32'(bus.s6), 32'(cur.s6));
    chk({tag, "_dz"}, 32'(bus.div_zero), 32'(cur.dz));
  endtask

  // Drive operands for one edge, push expectation, then scramble the
  // operand bus so late changes would show up as wrong results.
  task automatic start_op(input logic [BW-1:0] a, b, c, d);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.c = c; bus.d = d;
    bus.in_valid = 1'b1;
    chk("in_ready_pre", 32'(bus.in_ready), 1);
    sb.push_back(model(a, b, c, d));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = BW'($urandom); bus.b = BW'($urandom);
    bus.c = BW'($urandom); bus.d = BW'($urandom);
    chk("in_ready_busy", 32'(bus.in_ready), 0);
  endtask

  // Count edges from accept to out_valid, then pop and compare.
  task automatic wait_out(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), BW);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      cur = sb.pop_front();
      cmp_res(tag);
    end
  endtask

  task automatic hold_chk(input string tag, input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      chk({tag, "_ov_hold"}, 32'(bus.out_valid), 1);
      chk({tag, "_ir_hold"}, 32'(bus.in_ready), 0);
      cmp_res({tag, "_hold"});
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_after"}, 32'(bus.out_valid), 0);
    chk({tag, "_ir_after"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_ir", 32'(bus.in_ready), 0);
    chk("rst_s1", 32'(bus.s1), 0);
    chk("rst_s6", 32'(bus.s6), 0);
    chk("rst_dz", 32'(bus.div_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ir", 32'(bus.in_ready), 1);

    // Nominal, with explicit constants alongside the model
    start_op(8'd7, 8'd3, 8'd2, 8'd5);
    wait_out("nom");
    chk("nom_s3_const", 32'(bus.s3), 6);
    chk("nom_s6_const", 32'(bus.s6), 32);
    handshake("nom");

    // Wrap-around
    start_op(8'd200, 8'd100, 8'd0, 8'd0);
    wait_out("wrap");
    chk("wrap_s1_const", 32'(bus.s1), 44);
    chk("wrap_s6_const", 32'(bus.s6), 132);
    handshake("wrap");
    start_op(8'd3, 8'd5, 8'd0, 8'd0);
    wait_out("under");
    chk("under_s5_const", 32'(bus.s5), 254);
    handshake("under");

    // Divide by zero
    start_op(8'd9, 8'd0, 8'd1, 8'd4);
    wait_out("dz");
    chk("dz_s3_const", 32'(bus.s3), 13);
    chk("dz_flag_const", 32'(bus.div_zero), 1);
    handshake("dz");

    // Backpressure with in_valid held high; next accept one cycle after
    // the output handshake.
    start_op(8'd7, 8'd3, 8'd2, 8'd5);
    wait_out("bp");
    @(negedge clk);
    bus.a = 8'd200; bus.b = 8'd100; bus.c = 8'd0; bus.d = 8'd0;
    bus.in_valid = 1'b1;
    hold_chk("bp", 5);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ov_after", 32'(bus.out_valid), 0);
    chk("bp_ir_after", 32'(bus.in_ready), 1);
    sb.push_back(model(8'd200, 8'd100, 8'd0, 8'd0));
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_accepted", 32'(bus.in_ready), 0);
    wait_out("b2b");
    handshake("b2b");

    // Random operands, including some b == 0
    for (int i = 0; i < 8; i++) begin
      logic [BW-1:0] ra, rb, rc, rd;
      ra = BW'($urandom); rb = (i % 4 == 3) ? '0 : BW'($urandom);
      rc = BW'($urandom); rd = BW'($urandom);
      start_op(ra, rb, rc, rd);
      wait_out("rnd");
      handshake("rnd");
    end

    // Reset in the 4th DIV cycle
    start_op(8'd7, 8'd3, 8'd2, 8'd5);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_ov", 32'(bus.out_valid), 0);
    chk("mid_rst_ir", 32'(bus.in_ready), 0);
    chk("mid_rst_s1", 32'(bus.s1), 0);
    chk("mid_rst_s4", 32'(bus.s4), 0);
    chk("mid_rst_dz", 32'(bus.div_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (bus.out_valid) seen++;
      end
      chk("mid_rst_no_ov", 32'(seen), 0);
    end
    start_op(8'd7, 8'd3, 8'd2, 8'd5);
    wait_out("after_rst");
    handshake("after_rst");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
